ram_16x8_fifo_ctrl: RTL

//   Synchronous FIFO controller sitting directly upstream of the 16x8 RAM
//   (ram_16X8). It accepts push/pop requests from a producer and a consumer,

---
 rtl/ram_16x8_fifo_ctrl.sv | 88 ++++++++
 1 files changed

// File: rtl/ram_16x8_fifo_ctrl.sv
// FIFO controller for the 16x8 RAM: turns push/pop requests into RAM enables
// and addresses, and tracks occupancy plus sticky overflow/underflow flags.
module ram_16x8_fifo_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full_c, empty_c;
  logic          push_ok_c, pop_ok_c;

  // Wrap bit differs with equal addresses means full; identical means empty.
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);

  // Acceptance uses registered occupancy only, so full blocks push and empty
  // blocks pop even when the opposite request arrives in the same cycle.
  always_comb begin
    push_ok_c   = 1'b0;
    pop_ok_c    = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    push_ok_c = push & ~full_c;
    pop_ok_c  = pop & ~empty_c;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    rd_valid_d = pop_ok_c;
    if (push & full_c)  overflow_d  = 1'b1;
    if (pop & empty_c)  underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_wr_en   = push_ok_c;
  assign ram_wr_addr = wr_ptr_q[AW-1:0];
  assign ram_wr_data = push_data;
  assign ram_rd_en   = pop_ok_c;
  assign ram_rd_addr = rd_ptr_q[AW-1:0];
  assign rd_valid    = rd_valid_q;
  assign full        = full_c;
  assign empty       = empty_c;
  assign count       = wr_ptr_q - rd_ptr_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
